// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / commit bundle of the reorder buffer.
// With ROB_PERF_EN defined it also carries the commit and flush event counters.
interface reorder_buffer_if #(
   parameter int TAG_W  = 4,
   parameter int PREG_W = 6
);
   logic              disp_valid;
   logic              disp_ready;
   logic [4:0]        disp_rd_log;
   logic [PREG_W-1:0] disp_rd_phys;
   logic [PREG_W-1:0] disp_rd_old_phys;
   logic              disp_reg_write;
   logic              disp_is_branch;
   logic [31:0]       disp_pc;
   logic [TAG_W-1:0]  disp_tag;

   logic              wb_valid;
   logic [TAG_W-1:0]  wb_tag;
   logic              wb_mispredict;

   logic              commit_valid;
   logic [4:0]        commit_rd_log;
   logic [PREG_W-1:0] commit_rd_phys;
   logic [PREG_W-1:0] commit_free_phys;
   logic              commit_reg_write;
   logic [31:0]       commit_pc;
   logic              flush_valid;
   logic [31:0]       flush_pc;
   logic [TAG_W:0]    count;
`ifdef ROB_PERF_EN
   logic [31:0]       perf_commit_cnt;
   logic [31:0]       perf_flush_cnt;
`endif

   modport master (
      output disp_valid, disp_rd_log, disp_rd_phys, disp_rd_old_phys,
             disp_reg_write, disp_is_branch, disp_pc,
             wb_valid, wb_tag, wb_mispredict,
      input  disp_ready, disp_tag, commit_valid, commit_rd_log, commit_rd_phys,
             commit_free_phys, commit_reg_write, commit_pc, flush_valid, flush_pc,
             count
`ifdef ROB_PERF_EN
      , input perf_commit_cnt, perf_flush_cnt
`endif
   );

   modport slave (
      input  disp_valid, disp_rd_log, disp_rd_phys, disp_rd_old_phys,
             disp_reg_write, disp_is_branch, disp_pc,
             wb_valid, wb_tag, wb_mispredict,
      output disp_ready, disp_tag, commit_valid, commit_rd_log, commit_rd_phys,
             commit_free_phys, commit_reg_write, commit_pc, flush_valid, flush_pc,
             count
`ifdef ROB_PERF_EN
      , output perf_commit_cnt, perf_flush_cnt
`endif
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dispatch at tail, completion by tag, commit/flush from head.
// Optional ROB_PERF_EN adds 32-bit commit and flush event counters.
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int TAG_W  = 4,
   parameter int PREG_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   reorder_buffer_if.slave    rob
);
   typedef struct packed {
      logic [4:0]        rd_log;
      logic [PREG_W-1:0] rd_phys;
      logic [PREG_W-1:0] old_phys;
      logic              reg_write;
      logic [31:0]       pc;
   } entry_t;

   entry_t           mem_q   [DEPTH];
   logic             valid_q [DEPTH];
   logic             done_q  [DEPTH];
   logic             mis_q   [DEPTH];
   logic [TAG_W:0]   head_q, tail_q;

   logic [TAG_W-1:0] head_idx, tail_idx;
   logic             full, commit, flush, disp_fire, wb_hit;
   entry_t           head_e;
   logic             unused_is_branch;

   assign head_idx  = head_q[TAG_W-1:0];
   assign tail_idx  = tail_q[TAG_W-1:0];
   assign full      = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
   assign head_e    = mem_q[head_idx];
   assign commit    = valid_q[head_idx] && done_q[head_idx];
   assign flush     = commit && mis_q[head_idx];
   assign disp_fire = rob.disp_valid && rob.disp_ready;
   assign wb_hit    = rob.wb_valid && valid_q[rob.wb_tag];

   // Branch flag is carried for the front end; retirement only needs the mispredict bit.
   assign unused_is_branch = rob.disp_is_branch;

   assign rob.disp_ready       = !full && !flush;
   assign rob.disp_tag         = tail_idx;
   assign rob.count            = tail_q - head_q;
   assign rob.commit_valid     = commit;
   assign rob.commit_rd_log    = commit ? head_e.rd_log    : '0;
   assign rob.commit_rd_phys   = commit ? head_e.rd_phys   : '0;
   assign rob.commit_free_phys = commit ? head_e.old_phys  : '0;
   assign rob.commit_reg_write = commit ? head_e.reg_write : 1'b0;
   assign rob.commit_pc        = commit ? head_e.pc        : '0;
   assign rob.flush_valid      = flush;
   assign rob.flush_pc         = flush ? head_e.pc : '0;

   // Payload needs no reset: it is only observed while its valid bit is set.
   always_ff @(posedge clk) begin
      if (disp_fire && !flush)
         mem_q[tail_idx] <= '{rd_log:    rob.disp_rd_log,
                              rd_phys:   rob.disp_rd_phys,
                              old_phys:  rob.disp_rd_old_phys,
                              reg_write: rob.disp_reg_write,
                              pc:        rob.disp_pc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            done_q[i]  <= 1'b0;
            mis_q[i]   <= 1'b0;
         end
      end else if (flush) begin
         head_q <= head_q + 1'b1;
         tail_q <= head_q + 1'b1;
         for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      end else begin
         if (commit) begin
            valid_q[head_idx] <= 1'b0;
            head_q            <= head_q + 1'b1;
         end
         if (wb_hit) begin
            done_q[rob.wb_tag] <= 1'b1;
            mis_q[rob.wb_tag]  <= rob.wb_mispredict;
         end
         // Ordered last so a dispatch overrides a writeback to the same slot.
         if (disp_fire) begin
            valid_q[tail_idx] <= 1'b1;
            done_q[tail_idx]  <= 1'b0;
            mis_q[tail_idx]   <= 1'b0;
            tail_q            <= tail_q + 1'b1;
         end
      end
   end

`ifdef ROB_PERF_EN
   logic [31:0] perf_commit_q, perf_flush_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_commit_q <= '0;
         perf_flush_q  <= '0;
      end else begin
         if (commit) perf_commit_q <= perf_commit_q + 32'd1;
         if (flush)  perf_flush_q  <= perf_flush_q + 32'd1;
      end
   end
   assign rob.perf_commit_cnt = perf_commit_q;
   assign rob.perf_flush_cnt  = perf_flush_q;
`endif
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the OoO core.
- Dispatch writes one entry per cycle, carrying rename results (logical rd, new/old physical rd, branch flag, PC).
- Functional-unit writeback marks entries done.
- Entries are read out in program order at commit: the commit-side reader of the ROB-entry format.
- Commit frees the stale physical register to the free list and raises a pipeline flush on a mispredicted branch.

Parameters:
- DEPTH, 16, number of entries; power of two.
- TAG_W, 4, ROB tag width; equals log2(DEPTH).
- PREG_W, 6, physical register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  ROB can accept this cycle
- disp_rd_log  in  5  logical destination
- disp_rd_phys  in  PREG_W  new physical destination
- disp_rd_old_phys  in  PREG_W  previous mapping of rd, to free at commit
- disp_reg_write  in  1  instruction writes rd
- disp_is_branch  in  1  branch/jump
- disp_pc  in  32  instruction PC
- disp_tag  out  TAG_W  tag assigned to the dispatching instruction (current tail index)
- wb_valid  in  1  completion report
- wb_tag  in  TAG_W  completing entry
- wb_mispredict  in  1  completing branch mispredicted
- commit_valid  out  1  head entry retires this cycle
- commit_rd_log  out  5  logical rd of retiring entry
- commit_rd_phys  out  PREG_W  physical rd of retiring entry
- commit_free_phys  out  PREG_W  old physical reg to return to the free list
- commit_reg_write  out  1  retiring entry writes rd; free list acts only when high
- commit_pc  out  32  PC of retiring entry
- flush_valid  out  1  retiring entry is a mispredicted branch
- flush_pc  out  32  PC of the mispredicted branch
- count  out  TAG_W+1  occupied entries

Behaviour:
- Storage
  - Head and tail pointers are TAG_W+1 bits; the MSB is the wrap bit.
  - empty = (head == tail). full = indices equal and wrap bits differ.
  - count = tail - head, modulo 2^(TAG_W+1).
- Reset
  - All entry valid/done/mispredicted bits cleared; head = tail = 0.
  - All outputs 0, except disp_ready = 1 and disp_tag = 0.
- Dispatch
  - disp_ready = !full && !flush_valid, from registered state only (no combinational path from disp_valid).
  - Accept when disp_valid && disp_ready: entry[tail] gets valid=1, done=0, mispredicted=0 plus the payload.
  - disp_tag = tail index, combinational.
  - tail increments at the edge.
- Writeback
  - On wb_valid with entry[wb_tag].valid: set done=1, and mispredicted=wb_mispredict.
  - Writeback to an invalid entry is ignored.
  - A slot is never dispatched and written back in the same cycle; if it happens, dispatch wins.
- Commit
  - Combinational, one entry per cycle, no backpressure.
  - commit_valid = entry[head].valid && entry[head].done.
  - commit_* outputs reflect entry[head] and are 0 when commit_valid is low.
  - On commit: clear entry[head].valid and increment head.
  - Writeback to the head makes it committable the following cycle; minimum complete-to-commit latency is 1 cycle.
- Full / empty edge cases
  - Full with a commit in the same cycle: disp_ready stays 0 that cycle; the slot is usable next cycle.
  - Empty: commit_valid = 0 and count = 0.
- Flush
  - flush_valid = commit_valid && entry[head].mispredicted.
  - flush_pc = entry[head].pc.
  - The branch itself retires normally (commit_valid = 1, free list acts).
  - Next edge: all valid bits cleared, head = tail = head+1, count = 0.
  - Dispatch and writeback in the flush cycle are dropped.
- Reset mid-operation: asynchronous; all state returns to reset values immediately, in-flight entries discarded.

Optional Feature:
- ROB_PERF_EN: adds outputs perf_commit_cnt (32) and perf_flush_cnt (32).
  - perf_commit_cnt increments on every commit_valid.
  - perf_flush_cnt increments on every flush_valid.
  - Both wrap at 2^32 and reset to 0.
- Without the macro: no ports, no counter logic; behaviour otherwise identical.

Test Plan:
- Reset, then dispatch 3 entries (pc 0x100/0x104/0x108) -> disp_tag 0,1,2; count=3; commit_valid=0.
- Writeback tags 2,0,1 on consecutive cycles -> commits in order 0x100,0x104,0x108, each one cycle after its predecessor is both head and done; commit_free_phys matches the dispatched old_phys.
- Dispatch 16 with no writeback -> disp_ready=0, count=16. Then writeback+commit tag 0 -> disp_ready=1 the cycle after the commit; next dispatch gets tag 0, wrapped.
- Entries at tags 0,1,2; tag 1 branch pc 0x200 written back with wb_mispredict=1, all done -> tag 0 commits; then tag 1 commits with flush_valid=1, flush_pc=0x200. Next cycle count=0 and tag 2 never commits; the next dispatch gets tag 2.
- Writeback with wb_tag pointing at an invalid slot -> no state change; count unchanged.
- Assert rst_n low while count=5 -> count=0 and commit_valid=0 immediately (no clock edge required); disp_ready=1.
